// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared opcode and state types for the ALU execution unit
package definitions;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    SLL = 3'd2,
    SRA = 3'd3,
    SRL = 3'd4,
    GT  = 3'd5,
    EQ  = 3'd6,
    NEG = 3'd7
  } op_mne;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } alu_state_e;

  function automatic logic is_shift(input op_mne op);
    return (op == SLL) || (op == SRA) || (op == SRL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - one-bit shift of the accumulator, reporting the bit shifted out
module alu_shift_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic         dir_left,
  input  logic         arith,
  output logic [W-1:0] acc_next,
  output logic         out_bit
);

  always_comb begin
    acc_next = '0;
    out_bit  = 1'b0;
    if (dir_left) begin
      acc_next = {acc[W-2:0], 1'b0};
      out_bit  = acc[W-1];
    end else begin
      acc_next = {arith & acc[W-1], acc[W-1:1]};
      out_bit  = acc[0];
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execution unit with valid/ready request and response
module alu_exec_unit
  import definitions::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  op_mne        req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_flag,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W:0] W_EXT = (W + 1)'(W);

  alu_state_e    state_q, state_d;
  op_mne         op_q, op_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic [CW-1:0] req_cnt;
  logic [W:0]    sum;
  logic [W-1:0]  alu_res;
  logic          alu_flag;
  logic [W-1:0]  step_acc;
  logic          step_bit;

  assign req_ready  = (state_q == IDLE) || ((state_q == DONE) && rsp_ready);
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_result = acc_q;
  assign rsp_flag   = flag_q;

  // Saturate on the full-width b so large counts are never aliased by truncation.
  assign req_cnt = ({1'b0, req_b} >= W_EXT) ? CW'(W) : CW'(req_b);

  always_comb begin
    sum      = {1'b0, req_a} + {1'b0, req_b};
    alu_res  = req_a;
    alu_flag = 1'b0;
    case (req_op)
      ADD: begin
        alu_res  = sum[W-1:0];
        alu_flag = sum[W];
      end
      SUB: begin
        alu_res  = req_a - req_b;
        alu_flag = (req_a < req_b);
      end
      GT: begin
        alu_flag = (req_a > req_b);
        alu_res  = {{(W-1){1'b0}}, alu_flag};
      end
      EQ: begin
        alu_flag = (req_a == req_b);
        alu_res  = {{(W-1){1'b0}}, alu_flag};
      end
      NEG: begin
        alu_res  = -req_a;
        alu_flag = |req_a;
      end
      default: begin
        alu_res  = req_a;
        alu_flag = 1'b0;
      end
    endcase
  end

  alu_shift_step #(.W(W)) u_shift_step (
    .acc      (acc_q),
    .dir_left (op_q == SLL),
    .arith    (op_q == SRA),
    .acc_next (step_acc),
    .out_bit  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          op_d = req_op;
          if (is_shift(req_op) && (req_cnt != '0)) begin
            state_d = SHIFT;
            acc_d   = req_a;
            cnt_d   = req_cnt;
            flag_d  = 1'b0;
          end else begin
            state_d = DONE;
            acc_d   = alu_res;
            flag_d  = alu_flag;
          end
        end else if ((state_q == DONE) && rsp_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d  = step_acc;
        flag_d = step_bit;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= ADD;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
